seg_ring_chaser: RTL and testbench

//  Runs a lit segment (plus optional fading-free tail) around the outer ring of a row of
//  NUM_DISPLAYS seven-segment digits: top 'a' segments, right 'b','c' of the last digit,

---
 rtl/seg_ring_pkg.sv | 35 +++
 rtl/seg_ring_decode.sv | 69 ++++++
 rtl/seg_ring_chaser.sv | 101 ++++++++++
 tb/tb_seg_ring_chaser.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_ring_pkg.sv
// Shared constants and ring-geometry helpers for the seven-segment ring chaser.
// The ring runs clockwise: top a's, right b/c, bottom d's (right to left), left e/f.
package seg_ring_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  function automatic int ring_len(input int n);
    return 2 * n + 4;
  endfunction

  // Flat bit index inside the 7*n segment vector for clockwise ring position p.
  function automatic int seg_bit(input int p, input int n);
    int res;
    if (p < n)
      res = 7 * p + SEG_A;
    else if (p == n)
      res = 7 * (n - 1) + SEG_B;
    else if (p == n + 1)
      res = 7 * (n - 1) + SEG_C;
    else if (p <= 2 * n + 1)
      res = 7 * (n - 1 - (p - n - 2)) + SEG_D;
    else if (p == 2 * n + 2)
      res = SEG_E;
    else
      res = SEG_F;
    return res;
  endfunction

endpackage

// File: rtl/seg_ring_decode.sv
// Combinational map from head position, direction and tail length to the raw
// segment vector: the head plus up to TAIL_MAX positions trailing behind it.
module seg_ring_decode
  import seg_ring_pkg::*;
#(
  parameter int NUM_DISPLAYS = 6,
  parameter int TAIL_MAX     = 3,
  parameter int RING_LEN     = ring_len(NUM_DISPLAYS),
  parameter int POS_W        = $clog2(RING_LEN),
  parameter int TAIL_W       = $clog2(TAIL_MAX + 1)
) (
  input  logic [POS_W-1:0]          pos_i,
  input  logic                      dir_i,
  input  logic [TAIL_W-1:0]         tail_i,
  output logic [7*NUM_DISPLAYS-1:0] seg_o
);

  localparam logic [POS_W:0] RL = (POS_W + 1)'(RING_LEN);

  logic [TAIL_W:0]     w_tailWide;
  logic [POS_W:0]      w_tailEff;
  logic [POS_W:0]      w_dist;
  logic [RING_LEN-1:0] w_ring;

  // Tail requests beyond TAIL_MAX are clamped rather than wrapped.
  always_comb begin
    w_tailWide = {1'b0, tail_i};
    if (w_tailWide > (TAIL_W + 1)'(TAIL_MAX))
      w_tailEff = (POS_W + 1)'(TAIL_MAX);
    else
      w_tailEff = (POS_W + 1)'(tail_i);
  end

  // A position is lit when its distance behind the head (against the travel
  // direction) is within the tail length; distance 0 is the head itself.
  always_comb begin
    w_ring = '0;
    w_dist = '0;
    for (int r = 0; r < RING_LEN; r++) begin
      if (!dir_i)
        w_dist = {1'b0, pos_i} + RL - (POS_W + 1)'(r);
      else
        w_dist = (POS_W + 1)'(r) + RL - {1'b0, pos_i};
      if (w_dist >= RL)
        w_dist = w_dist - RL;
      w_ring[r] = (w_dist <= w_tailEff);
    end
  end

  function automatic int pos_of_bit(input int b);
    int res;
    res = -1;
    for (int r = 0; r < RING_LEN; r++)
      if (seg_bit(r, NUM_DISPLAYS) == b)
        res = r;
    return res;
  endfunction

  // Segments not on the outer ring (inner b/c/e/f and every g) stay dark.
  for (genvar b = 0; b < 7 * NUM_DISPLAYS; b++) begin : g_bit
    localparam int P = pos_of_bit(b);
    if (P < 0 || (b % 7) == SEG_G) begin : g_off
      assign seg_o[b] = 1'b0;
    end else begin : g_on
      assign seg_o[b] = w_ring[P[POS_W-1:0]];
    end
  end

endmodule

// File: rtl/seg_ring_chaser.sv
// Ring chaser top: step prescaler, head position counter, wrap pulse and the
// registered segment output that feeds the display multiplexer.
module seg_ring_chaser
  import seg_ring_pkg::*;
#(
  parameter  int NUM_DISPLAYS = 6,
  parameter  int PRESC_W      = 24,
  parameter  int TAIL_MAX     = 3,
  localparam int RING_LEN     = ring_len(NUM_DISPLAYS),
  localparam int POS_W        = $clog2(RING_LEN),
  localparam int TAIL_W       = $clog2(TAIL_MAX + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic                      dir_i,
  input  logic [PRESC_W-1:0]        step_div_i,
  input  logic [TAIL_W-1:0]         tail_i,
  output logic [7*NUM_DISPLAYS-1:0] seg_o,
  output logic [POS_W-1:0]          pos_o,
  output logic                      wrap_o
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(RING_LEN - 1);

  logic [PRESC_W-1:0]        r_cnt;
  logic [POS_W-1:0]          r_pos;
  logic                      r_wrap;
  logic [7*NUM_DISPLAYS-1:0] r_seg;
  logic [7*NUM_DISPLAYS-1:0] w_seg;
  logic [POS_W-1:0]          w_posNext;
  logic                      w_step;
  logic                      w_atWrap;

  // '>=' lets a shortened divider take effect at once instead of waiting for
  // the counter to roll over the full register width.
  assign w_step = enable_i && (r_cnt >= step_div_i);

  always_comb begin
    w_posNext = r_pos;
    w_atWrap  = 1'b0;
    if (!dir_i) begin
      w_atWrap  = (r_pos == POS_LAST);
      w_posNext = w_atWrap ? '0 : r_pos + 1'b1;
    end else begin
      w_atWrap  = (r_pos == '0);
      w_posNext = w_atWrap ? POS_LAST : r_pos - 1'b1;
    end
  end

  // Clear outranks stepping and also swallows the wrap pulse of that edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else if (clear_i) begin
      r_cnt  <= '0;
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_step && w_atWrap;
      if (enable_i) begin
        if (w_step) begin
          r_cnt <= '0;
          r_pos <= w_posNext;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  seg_ring_decode #(
    .NUM_DISPLAYS (NUM_DISPLAYS),
    .TAIL_MAX     (TAIL_MAX),
    .RING_LEN     (RING_LEN),
    .POS_W        (POS_W),
    .TAIL_W       (TAIL_W)
  ) u_decode (
    .pos_i  (r_pos),
    .dir_i  (dir_i),
    .tail_i (tail_i),
    .seg_o  (w_seg)
  );

  // Segment image lags the position register by one clock and keeps tracking
  // tail/direction even while stepping is frozen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_seg <= '0;
    else
      r_seg <= w_seg;
  end

  assign seg_o  = r_seg;
  assign pos_o  = r_pos;
  assign wrap_o = r_wrap;

endmodule

// File: tb/tb_seg_ring_chaser.sv
// Scoreboard bench for seg_ring_chaser (6 digits, 16-position ring, tail up to 3).
// Stimulus pushes per-edge expectations; a negedge monitor pops and compares.
module tb_seg_ring_chaser;

  localparam int N      = 6;
  localparam int PRESCW = 24;

  // Hand-derived flat segment bit for each clockwise ring position.
  localparam int RING_BIT [16] = '{0, 7, 14, 21, 28, 35, 36, 37, 38, 31, 24, 17, 10, 3, 4, 5};

  typedef struct {
    int         tag;
    bit         chkPos;
    logic [3:0] pos;
    bit         chkSeg;
    logic [41:0] seg;
    bit         chkWrap;
    logic       wrap;
  } expT;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              enable = 1'b1;
  logic              clear = 1'b0;
  logic              dir = 1'b0;
  logic [PRESCW-1:0] stepDiv = '0;
  logic [1:0]        tail = '0;
  logic [7*N-1:0]    seg;
  logic [3:0]        pos;
  logic              wrap;

  expT expQ[$];
  int  checkCount = 0;
  int  passCount  = 0;

  seg_ring_chaser #(
    .NUM_DISPLAYS (N),
    .PRESC_W      (PRESCW),
    .TAIL_MAX     (3)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .enable_i   (enable),
    .clear_i    (clear),
    .dir_i      (dir),
    .step_div_i (stepDiv),
    .tail_i     (tail),
    .seg_o      (seg),
    .pos_o      (pos),
    .wrap_o     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] segOf(input int p);
    logic [41:0] v;
    v = '0;
    v[RING_BIT[p]] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Drive one cycle's inputs just after the negedge, clear of the active edge.
  task automatic applyStimulus(input logic en, input logic clr, input logic d,
                               input int div, input int t);
    @(negedge clk);
    #1;
    enable  = en;
    clear   = clr;
    dir     = d;
    stepDiv = PRESCW'(div);
    tail    = 2'(t);
  endtask

  task automatic expectNext(input int tag, input bit cp, input int p,
                            input bit cs, input logic [41:0] s,
                            input bit cw, input logic w);
    expT e;
    e.tag = tag; e.chkPos = cp; e.pos = 4'(p);
    e.chkSeg = cs; e.seg = s; e.chkWrap = cw; e.wrap = w;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    expT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (e.chkPos)  checkOutput($sformatf("t%0d_pos", e.tag), 64'(pos), 64'(e.pos));
      if (e.chkSeg)  checkOutput($sformatf("t%0d_seg", e.tag), 64'(seg), 64'(e.seg));
      if (e.chkWrap) checkOutput($sformatf("t%0d_wrap", e.tag), 64'(wrap), 64'(e.wrap));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    checkOutput("reset_pos", 64'(pos), 64'd0);
    checkOutput("reset_seg", 64'(seg), 64'd0);
    checkOutput("reset_wrap", 64'(wrap), 64'd0);

    // 1: full lap at one step per clock, head walks the ring map, single wrap
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      if (k == 1) rstN = 1'b1;
      expectNext(1, 1, k % 16, 1, segOf((k - 1) % 16), 1, k == 16);
    end

    // 2: divide by 4, then shrink divider mid-count
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 3, 0);
      expectNext(2, 1, 1 + j / 4, 0, '0, 1, 1'b0);
    end
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 9, 0);
      expectNext(2, 1, 3, 0, '0, 0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 0);
    expectNext(2, 1, 4, 0, '0, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 0);
    expectNext(2, 1, 4, 0, '0, 0, 1'b0);

    // 3: counter-clockwise wrap from 0, then a reversal mid-interval
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    expectNext(3, 1, 0, 0, '0, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 0);
    expectNext(3, 1, 15, 0, '0, 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 0);
    expectNext(3, 1, 14, 1, 42'(1) << 5, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3, 0);
    expectNext(3, 1, 14, 0, '0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 0);
    expectNext(3, 1, 14, 0, '0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 0);
    expectNext(3, 1, 14, 0, '0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 0);
    expectNext(3, 1, 15, 0, '0, 1, 1'b0);

    // 4: tails behind head at pos 1 (max 2-bit tail value is the clamp limit)
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    expectNext(4, 1, 0, 0, '0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    expectNext(4, 1, 1, 0, '0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 2);
    expectNext(4, 1, 1, 1, (42'(1) << 7) | 42'(1) | (42'(1) << 5), 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 3);
    expectNext(4, 0, 0, 1, (42'(1) << 7) | 42'(1) | (42'(1) << 5) | (42'(1) << 4), 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 3);
    expectNext(4, 0, 0, 1, (42'(1) << 7) | (42'(1) << 14) | (42'(1) << 21) | (42'(1) << 28), 0, 1'b0);

    // 5: frozen for 20 cycles, then clear while disabled
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
      expectNext(5, 1, 1, 1, segOf(1), 1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    expectNext(5, 1, 0, 0, '0, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    expectNext(5, 1, 0, 1, segOf(0), 1, 1'b0);

    // 6: async reset mid-lap, then clear colliding with a wrapping step
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      expectNext(6, 1, k, 0, '0, 0, 1'b0);
    end
    @(negedge clk);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_pos", 64'(pos), 64'd0);
    checkOutput("async_rst_seg", 64'(seg), 64'd0);
    checkOutput("async_rst_wrap", 64'(wrap), 64'd0);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      if (k == 1) rstN = 1'b1;
      expectNext(6, 1, k, 0, '0, 0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    expectNext(6, 1, 0, 0, '0, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    expectNext(6, 1, 1, 0, '0, 1, 1'b0);

    @(negedge clk);
    #2;
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
